fifo_uart_tx: RTL

- Pop-side consumer of the team's valid/grant FIFO: drains words from a FIFO pop interface and serialises each one onto a single UART TX line.
- Frame format: start bit, data bits LSB first, optional even parity, stop bit(s).
- Sits between the FIFO output and the chip pad. It is the reader/drain end of the FIFO push/pop protocol.

---
 rtl/uart_pkg.sv | 17 +
 rtl/baud_counter.sv | 41 ++++
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the FIFO-draining UART transmitter.
package uart_pkg;

  // Transmitter frame phases; IDLE doubles as the "ready for a word" state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

  // Serial line levels: the line rests high and a frame opens with a low start bit.
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the last one.
module baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // tick only looks at the count, never at clear_i, so the owner may derive clear_i from tick_o
  assign tick_o = (count_q == LAST_COUNT);

  // Next count: restart on clear, wrap at the bit boundary, otherwise advance.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q == LAST_COUNT) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO pop-side UART transmitter: takes one word per frame through the valid/grant
// handshake and serialises it as start, data LSB first, optional even parity, stop bit(s).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pop_valid_i,
  input  logic [DATA_WIDTH-1:0] pop_data_i,
  output logic                  pop_grant_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP_BIT = BCW'(STOP_BITS - 1);

  txState_t              state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bitCnt_q, bitCnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;

  logic bitTick;
  logic lastStopCycle;
  logic transfer;
  logic baudClear;

  // The counter is held at zero while idle and restarted on every accepted word,
  // so each frame's start bit lasts a full bit period from the handshake edge.
  assign baudClear = (state_q == IDLE) || transfer;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear_i(baudClear),
    .tick_o (bitTick)
  );

  // Grant depends only on state and counters so the FIFO sees no path from its own valid.
  assign lastStopCycle = (state_q == STOP) && bitTick && (bitCnt_q == LAST_STOP_BIT);
  assign pop_grant_o   = (state_q == IDLE) || lastStopCycle;
  assign transfer      = pop_valid_i && pop_grant_o;

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);

  // Frame sequencing: capture on transfer, otherwise advance one phase per bit tick.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    parity_d = parity_q;
    tx_d     = tx_q;

    if (transfer) begin
      state_d  = START;
      tx_d     = START_LEVEL;
      shift_d  = pop_data_i;
      parity_d = ^pop_data_i;
      bitCnt_d = '0;
    end else if (bitTick) begin
      unique case (state_q)
        START: begin
          state_d  = DATA;
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
          bitCnt_d = '0;
        end
        DATA: begin
          if (bitCnt_q == LAST_DATA_BIT) begin
            bitCnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            bitCnt_d = bitCnt_q + BCW'(1);
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
        PARITY: begin
          state_d  = STOP;
          tx_d     = IDLE_LEVEL;
          bitCnt_d = '0;
        end
        STOP: begin
          if (bitCnt_q == LAST_STOP_BIT) begin
            state_d  = IDLE;
            tx_d     = IDLE_LEVEL;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + BCW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
        end
      endcase
    end
  end

  // Frame state registers; reset abandons any frame and returns the line high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      parity_q <= 1'b0;
      tx_q     <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

endmodule
